coef_fetch: RTL and testbench

- Reader side of the coefficient ROM in the FIR datapath.
- On a start pulse it walks TAPS consecutive ROM addresses and absorbs the ROM's one-cycle registered read latency.
- It delivers each coefficient with its tap index on a valid/ready stream to the MAC, and flags the last tap and completion.
- A 2-entry skid buffer lets downstream stall without losing in-flight ROM reads.

---
 rtl/coef_fetch.sv | 160 ++++++++++++++++
 tb/tb_coef_fetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_fetch.sv
// Coefficient ROM reader for the FIR datapath. It walks TAPS addresses from BASE, hides the ROM's
// one-cycle read latency, and streams {coef, coef_idx, coef_last} through a 2-entry skid buffer.
module coef_fetch #(
  parameter int unsigned N    = 8,
  parameter int unsigned AW   = 8,
  parameter int unsigned TAPS = 8,
  parameter int unsigned BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_address,
  input  logic [N-1:0]  rom_data,
  output logic [N-1:0]  coef,
  output logic [AW-1:0] coef_idx,
  output logic          coef_valid,
  output logic          coef_last,
  input  logic          coef_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CntW = AW + 1;
  localparam logic [AW-1:0]   BaseAddr = AW'(BASE);
  localparam logic [CntW-1:0] NumTaps  = CntW'(TAPS);
  localparam logic [CntW-1:0] LastIss  = CntW'(TAPS - 1);
  localparam logic [AW-1:0]   LastIdx  = AW'(TAPS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] issued_q;
  logic [AW-1:0]   addr_q;
  logic            busy_q, done_q;

  // Tag and tap index of the read whose data is on rom_data this cycle.
  logic            fl_q;
  logic [AW-1:0]   fl_idx_q;

  // Skid buffer: entry 0 is the head.
  logic [1:0]      cnt_q, cnt_d;
  logic [N-1:0]    d0_q, d0_d, d1_q, d1_d;
  logic [AW-1:0]   i0_q, i0_d, i1_q, i1_d;

  logic            pop, credit, issue, last_issue, last_pop;

  always_comb begin
    pop        = (cnt_q != 2'd0) && coef_ready;
    // Entries left after this pop plus the read landing this cycle must leave room for a new read.
    credit     = ((cnt_q - {1'b0, pop}) + {1'b0, fl_q}) < 2'd2;
    issue      = (state_q == StFetch) && (issued_q < NumTaps) && credit;
    last_issue = issue && (issued_q == LastIss);
    last_pop   = pop && (i0_q == LastIdx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      issued_q <= '0;
      addr_q   <= BaseAddr;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fl_q     <= 1'b0;
      fl_idx_q <= '0;
    end else begin
      fl_q   <= issue;
      done_q <= 1'b0;
      if (issue) begin
        fl_idx_q <= issued_q[AW-1:0];
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StFetch;
            issued_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StFetch: begin
          if (issue) begin
            issued_q <= issued_q + CntW'(1);
            if (last_issue) begin
              state_q <= StDrain;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        StDrain: begin
          if (last_pop) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            addr_q  <= BaseAddr;
          end
        end
        StDone: begin
          if (start) begin
            state_q  <= StFetch;
            issued_q <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    i0_d  = i0_q;
    i1_d  = i1_q;
    if (pop) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd2) begin
        d0_d = d1_q;
        i0_d = i1_q;
      end
    end
    if (fl_q) begin
      if (cnt_d == 2'd0) begin
        d0_d = rom_data;
        i0_d = fl_idx_q;
      end else begin
        d1_d = rom_data;
        i1_d = fl_idx_q;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
      d1_q  <= '0;
      i0_q  <= '0;
      i1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      i0_q  <= i0_d;
      i1_q  <= i1_d;
    end
  end

  assign rom_address = addr_q;
  assign coef        = d0_q;
  assign coef_idx    = i0_q;
  assign coef_valid  = (cnt_q != 2'd0);
  assign coef_last   = coef_valid && (i0_q == LastIdx);
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_coef_fetch.sv
// Directed bench for coef_fetch: three instances (8 taps at 0, 4 taps wrapping at 254, 1 tap at 5)
// each fed by a registered ROM model whose contents are a fixed function of the address.
module tb_coef_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_start, a_ready, a_valid, a_last, a_busy, a_done;
  logic [7:0] a_addr, a_rdata, a_coef, a_idx;
  logic       b_start, b_ready, b_valid, b_last, b_busy, b_done;
  logic [7:0] b_addr, b_rdata, b_coef, b_idx;
  logic       c_start, c_ready, c_valid, c_last, c_busy, c_done;
  logic [7:0] c_addr, c_rdata, c_coef, c_idx;

  int npass  = 0;
  int ntotal = 0;

  function automatic logic [7:0] romval(input logic [7:0] a);
    return (a * 8'd37) + 8'd11;
  endfunction

  always @(posedge clk) a_rdata <= romval(a_addr);
  always @(posedge clk) b_rdata <= romval(b_addr);
  always @(posedge clk) c_rdata <= romval(c_addr);

  coef_fetch #(.N(8), .AW(8), .TAPS(8), .BASE(0)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .rom_address(a_addr), .rom_data(a_rdata),
    .coef(a_coef), .coef_idx(a_idx), .coef_valid(a_valid), .coef_last(a_last),
    .coef_ready(a_ready), .busy(a_busy), .done(a_done)
  );

  coef_fetch #(.N(8), .AW(8), .TAPS(4), .BASE(254)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .rom_address(b_addr), .rom_data(b_rdata),
    .coef(b_coef), .coef_idx(b_idx), .coef_valid(b_valid), .coef_last(b_last),
    .coef_ready(b_ready), .busy(b_busy), .done(b_done)
  );

  coef_fetch #(.N(8), .AW(8), .TAPS(1), .BASE(5)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .rom_address(c_addr), .rom_data(c_rdata),
    .coef(c_coef), .coef_idx(c_idx), .coef_valid(c_valid), .coef_last(c_last),
    .coef_ready(c_ready), .busy(c_busy), .done(c_done)
  );

  // Every test starts and ends 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) reset = 1'b0;
      @(negedge clk);
      ntotal++;
      if ({a_addr, a_coef, a_idx, a_valid, a_last, a_busy, a_done} !== {8'd0, 8'd0, 8'd0, 4'b0000})
        $display("FAIL reset_a step %0d: got addr=%0d coef=%0d idx=%0d v/l/b/d=%b%b%b%b want all 0",
                 k, a_addr, a_coef, a_idx, a_valid, a_last, a_busy, a_done);
      else npass++;
      ntotal++;
      if ({b_addr, b_valid, b_busy, b_done} !== {8'd254, 3'b000})
        $display("FAIL reset_b step %0d: got addr=%0d v/b/d=%b%b%b want addr=254 000",
                 k, b_addr, b_valid, b_busy, b_done);
      else npass++;
      ntotal++;
      if ({c_addr, c_valid, c_busy, c_done} !== {8'd5, 3'b000})
        $display("FAIL reset_c step %0d: got addr=%0d v/b/d=%b%b%b want addr=5 000",
                 k, c_addr, c_valid, c_busy, c_done);
      else npass++;
      next_cycle();
    end
  endtask

  task automatic test_burst(input string tag);
    logic       ev, el, eb, ed;
    logic [7:0] ea, ei;
    for (int k = 0; k <= 13; k++) begin
      a_start = (k == 0);
      a_ready = 1'b1;
      @(negedge clk);
      ev = (k >= 3) && (k <= 10);
      el = (k == 10);
      eb = (k >= 1) && (k <= 10);
      ed = (k == 11);
      ea = (k >= 1 && k <= 8) ? 8'(k - 1) : ((k == 9 || k == 10) ? 8'd7 : 8'd0);
      ei = 8'(k - 3);
      ntotal++;
      if ({a_valid, a_last, a_busy, a_done} !== {ev, el, eb, ed})
        $display("FAIL %s flags cycle %0d: got v/l/b/d=%b%b%b%b want %b%b%b%b", tag, k,
                 a_valid, a_last, a_busy, a_done, ev, el, eb, ed);
      else npass++;
      ntotal++;
      if (a_addr !== ea)
        $display("FAIL %s rom_address cycle %0d: got %0d want %0d", tag, k, a_addr, ea);
      else npass++;
      if (ev) begin
        ntotal++;
        if ({a_idx, a_coef} !== {ei, romval(ei)})
          $display("FAIL %s data cycle %0d: got idx=%0d coef=%0d want idx=%0d coef=%0d", tag, k,
                   a_idx, a_coef, ei, romval(ei));
        else npass++;
      end
      next_cycle();
    end
    a_start = 1'b0;
  endtask

  task automatic test_stall();
    int         exp_addr [17] = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 7, 7, 0, 0};
    int         exp_idx  [12] = '{0, 1, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7};
    logic       ev, el, eb, ed;
    logic [7:0] ei;
    int         taken = 0;
    for (int k = 0; k <= 16; k++) begin
      a_start = (k == 0);
      a_ready = !(k >= 4 && k <= 7);
      @(negedge clk);
      ev = (k >= 3) && (k <= 14);
      el = (k == 14);
      eb = (k >= 1) && (k <= 14);
      ed = (k == 15);
      ntotal++;
      if ({a_valid, a_last, a_busy, a_done} !== {ev, el, eb, ed})
        $display("FAIL stall flags cycle %0d: got v/l/b/d=%b%b%b%b want %b%b%b%b", k,
                 a_valid, a_last, a_busy, a_done, ev, el, eb, ed);
      else npass++;
      ntotal++;
      if (a_addr !== 8'(exp_addr[k]))
        $display("FAIL stall rom_address cycle %0d: got %0d want %0d", k, a_addr, exp_addr[k]);
      else npass++;
      if (ev) begin
        ei = 8'(exp_idx[k - 3]);
        ntotal++;
        if ({a_idx, a_coef} !== {ei, romval(ei)})
          $display("FAIL stall data cycle %0d: got idx=%0d coef=%0d want idx=%0d coef=%0d", k,
                   a_idx, a_coef, ei, romval(ei));
        else npass++;
      end
      if (a_valid && a_ready) taken++;
      next_cycle();
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    ntotal++;
    if (taken !== 8) $display("FAIL stall count: got %0d coefs want 8", taken);
    else npass++;
  endtask

  task automatic test_wrap();
    int         exp_addr [10] = '{254, 254, 255, 0, 1, 1, 1, 254, 254, 254};
    logic       ev, el, eb, ed;
    logic [7:0] ei;
    for (int k = 0; k <= 9; k++) begin
      b_start = (k == 0);
      b_ready = 1'b1;
      @(negedge clk);
      ev = (k >= 3) && (k <= 6);
      el = (k == 6);
      eb = (k >= 1) && (k <= 6);
      ed = (k == 7);
      ntotal++;
      if ({b_valid, b_last, b_busy, b_done} !== {ev, el, eb, ed})
        $display("FAIL wrap flags cycle %0d: got v/l/b/d=%b%b%b%b want %b%b%b%b", k,
                 b_valid, b_last, b_busy, b_done, ev, el, eb, ed);
      else npass++;
      ntotal++;
      if (b_addr !== 8'(exp_addr[k]))
        $display("FAIL wrap rom_address cycle %0d: got %0d want %0d", k, b_addr, exp_addr[k]);
      else npass++;
      if (ev) begin
        ei = 8'(k - 3);
        ntotal++;
        if ({b_idx, b_coef} !== {ei, romval(8'd254 + ei)})
          $display("FAIL wrap data cycle %0d: got idx=%0d coef=%0d want idx=%0d coef=%0d", k,
                   b_idx, b_coef, ei, romval(8'd254 + ei));
        else npass++;
      end
      next_cycle();
    end
    b_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n1 = 0;
    int n2 = 0;
    for (int k = 0; k <= 24; k++) begin
      a_start = (k == 0) || (k == 5) || (k == 11);
      a_ready = 1'b1;
      @(negedge clk);
      ntotal++;
      if (a_done !== ((k == 11) || (k == 22)))
        $display("FAIL b2b done cycle %0d: got %b want %b", k, a_done, (k == 11) || (k == 22));
      else npass++;
      if (a_valid) begin
        ntotal++;
        if (a_idx !== 8'((k <= 11) ? n1 : n2))
          $display("FAIL b2b order cycle %0d: got idx=%0d want %0d", k, a_idx,
                   (k <= 11) ? n1 : n2);
        else npass++;
        if (k <= 11) n1++;
        else n2++;
      end
      if (k == 12 || k == 13) begin
        ntotal++;
        if ({a_busy, a_addr} !== {1'b1, 8'(k - 12)})
          $display("FAIL b2b restart cycle %0d: got busy=%b addr=%0d want busy=1 addr=%0d", k,
                   a_busy, a_addr, k - 12);
        else npass++;
      end
      next_cycle();
    end
    a_start = 1'b0;
    ntotal++;
    if ({n1, n2} !== {32'd8, 32'd8})
      $display("FAIL b2b counts: got %0d and %0d coefs want 8 and 8", n1, n2);
    else npass++;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k <= 12; k++) begin
      a_start = (k == 0);
      a_ready = 1'b1;
      reset   = (k == 6);
      @(negedge clk);
      if (k == 5) begin
        ntotal++;
        if ({a_valid, a_busy, a_idx} !== {2'b11, 8'd2})
          $display("FAIL midrst pre cycle %0d: got v=%b b=%b idx=%0d want v=1 b=1 idx=2", k,
                   a_valid, a_busy, a_idx);
        else npass++;
      end
      if (k == 7) begin
        ntotal++;
        if ({a_addr, a_coef, a_idx, a_valid, a_last, a_busy, a_done} !== {8'd0, 8'd0, 8'd0, 4'b0000})
          $display("FAIL midrst values: got addr=%0d coef=%0d idx=%0d v/l/b/d=%b%b%b%b want all 0",
                   a_addr, a_coef, a_idx, a_valid, a_last, a_busy, a_done);
        else npass++;
      end
      if (k > 7) begin
        ntotal++;
        if ({a_valid, a_busy, a_done} !== 3'b000)
          $display("FAIL midrst quiet cycle %0d: got v/b/d=%b%b%b want 000", k,
                   a_valid, a_busy, a_done);
        else npass++;
      end
      next_cycle();
    end
    reset   = 1'b0;
    a_start = 1'b0;
  endtask

  task automatic test_single();
    logic ev, eb, ed;
    for (int k = 0; k <= 6; k++) begin
      c_start = (k == 0);
      c_ready = 1'b1;
      @(negedge clk);
      ev = (k == 3);
      eb = (k >= 1) && (k <= 3);
      ed = (k == 4);
      ntotal++;
      if ({c_valid, c_last, c_busy, c_done, c_addr} !== {ev, ev, eb, ed, 8'd5})
        $display("FAIL single cycle %0d: got v/l/b/d=%b%b%b%b addr=%0d want %b%b%b%b addr=5", k,
                 c_valid, c_last, c_busy, c_done, c_addr, ev, ev, eb, ed);
      else npass++;
      if (ev) begin
        ntotal++;
        if ({c_idx, c_coef} !== {8'd0, romval(8'd5)})
          $display("FAIL single data: got idx=%0d coef=%0d want idx=0 coef=%0d", c_idx, c_coef,
                   romval(8'd5));
        else npass++;
      end
      next_cycle();
    end
    c_start = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    c_ready = 1'b1;
    repeat (3) next_cycle();
    test_reset();
    test_burst("burst");
    repeat (2) next_cycle();
    test_stall();
    repeat (2) next_cycle();
    test_wrap();
    repeat (2) next_cycle();
    test_back_to_back();
    repeat (2) next_cycle();
    test_mid_reset();
    test_burst("after_reset");
    repeat (2) next_cycle();
    test_single();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule
